mem_order_checker: RTL and testbench

Synthesizable result checker for multicycle CPU bring-up. It arms at reset and triggers on a start pulse or when the CPU PC reaches a parametrised halt address. It then scans N consecutive words of a data memory through a read port and verifies their ordering under a selectable compare mode. It reports pass/fail, the first failing index, and a watchdog timeout, so the board and the bench get a single verdict instead of hand-written memory comparisons.

---
 rtl/cpu_check_pkg.sv | 21 ++
 rtl/order_cmp.sv | 24 ++
 rtl/mem_order_checker.sv | 206 ++++++++++++++++++++
 tb/tb_mem_order_checker.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_check_pkg.sv
// Shared encodings for the memory ordering checker: FSM states, compare modes
// and default trigger/watchdog settings.
package cpu_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_TOUT  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_ASC_U  = 2'd0;
  localparam logic [1:0] MODE_ASC_S  = 2'd1;
  localparam logic [1:0] MODE_ASC_NS = 2'd2;
  localparam logic [1:0] MODE_DESC_U = 2'd3;

  localparam int unsigned DEF_HALT_PC     = 92;
  localparam int unsigned DEF_TIMEOUT_CYC = 4000;

endpackage

// File: rtl/order_cmp.sv
// Combinational ordering test between the previous and current element;
// ok=1 when cur may legally follow prev under the selected mode.
module order_cmp
  import cpu_check_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] prev,
  input  logic [DATA_W-1:0] cur,
  input  logic [1:0]        mode,
  output logic              ok
);

  always_comb begin
    ok = 1'b0;
    case (mode)
      MODE_ASC_U:  ok = (cur > prev);
      MODE_ASC_S:  ok = ($signed(cur) > $signed(prev));
      MODE_ASC_NS: ok = (cur >= prev);
      default:     ok = (cur < prev);
    endcase
  end

endmodule

// File: rtl/mem_order_checker.sv
// Scans count words of data memory after a start pulse or halt-PC hit and
// reports whether they are ordered, the first bad index, and a watchdog verdict.
//
// state    | meaning
// ST_IDLE  | armed, waiting for start or pc==HALT_PC; watchdog running
// ST_FETCH | issuing one read per cycle, comparing returned data
// ST_DRAIN | all reads issued, waiting for the last element to compare
// ST_DONE  | verdict latched, terminal until reset
// ST_TOUT  | watchdog expired before any trigger, terminal until reset
module mem_order_checker
  import cpu_check_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 32,
  parameter int          CNT_W       = 8,
  parameter int          WORD_BYTES  = 4,
  parameter int unsigned HALT_PC     = DEF_HALT_PC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [1:0]        mode,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  fail_idx,
  output logic [31:0]       cycles
);

  localparam logic [31:0] HALT_PC_W = 32'(HALT_PC);
  localparam bit          WDOG_EN   = (TIMEOUT_CYC != 0);
  localparam logic [31:0] WDOG_INIT = WDOG_EN ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic                rd_vld_q, rd_vld_d;
  logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
  logic                cap_vld_q, cap_vld_d;
  logic [CNT_W-1:0]    cap_idx_q, cap_idx_d;
  logic [DATA_W-1:0]   cap_data_q, cap_data_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    fail_idx_q, fail_idx_d;
  logic [31:0]         cycles_q, cycles_d;
  logic [31:0]         wdog_q, wdog_d;

  logic                trig;
  logic                scan_active;
  logic                verdict_st;
  logic                cap_live;
  logic                cap_first;
  logic                ok;
  logic                violation;
  logic                last_ok;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;

  order_cmp #(
    .DATA_W (DATA_W)
  ) u_order_cmp (
    .prev (prev_q),
    .cur  (cap_data_q),
    .mode (mode_q),
    .ok   (ok)
  );

  assign trig        = start || (pc == HALT_PC_W);
  assign scan_active = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign verdict_st  = (state_q == ST_DONE) || (state_q == ST_TOUT);
  assign cap_live    = scan_active && cap_vld_q;
  assign cap_first   = (cap_idx_q == '0);
  assign violation   = cap_live && !cap_first && !ok;
  assign last_ok     = cap_live && !violation && (cap_idx_q == count_q - CNT_W'(1));
  // A detected violation suppresses the read that would issue in the same cycle.
  assign rd_en       = (state_q == ST_FETCH) && !violation;
  assign rd_addr     = base_q + ADDR_W'(idx_q) * ADDR_W'(WORD_BYTES);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    fail_idx_d = fail_idx_q;
    wdog_d     = wdog_q;
    rd_vld_d   = rd_en;
    rd_idx_d   = idx_q;
    cap_vld_d  = rd_vld_q;
    cap_idx_d  = rd_idx_q;
    cap_data_d = rd_vld_q ? mem_rdata : cap_data_q;
    prev_d     = (cap_live && (cap_first || ok)) ? cap_data_q : prev_q;
    cycles_d   = (!verdict_st && (cycles_q != '1)) ? cycles_q + 32'd1 : cycles_q;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          base_d  = base_addr;
          count_d = count;
          mode_d  = mode;
          idx_d   = '0;
          if (count < CNT_W'(2)) begin
            state_d = ST_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (WDOG_EN && (wdog_q == '0)) begin
          state_d   = ST_TOUT;
          timeout_d = 1'b1;
        end else if (WDOG_EN) begin
          wdog_d = wdog_q - 32'd1;
        end
      end
      ST_FETCH: begin
        if (violation) begin
          state_d    = ST_DONE;
          pass_d     = 1'b0;
          fail_idx_d = cap_idx_q;
        end else begin
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == count_q - CNT_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (violation) begin
          state_d    = ST_DONE;
          pass_d     = 1'b0;
          fail_idx_d = cap_idx_q;
        end else if (last_ok) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
        end
      end
      ST_DONE, ST_TOUT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      mode_q     <= '0;
      idx_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      cap_vld_q  <= 1'b0;
      cap_idx_q  <= '0;
      cap_data_q <= '0;
      prev_q     <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fail_idx_q <= '0;
      cycles_q   <= '0;
      wdog_q     <= WDOG_INIT;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
      cap_vld_q  <= cap_vld_d;
      cap_idx_q  <= cap_idx_d;
      cap_data_q <= cap_data_d;
      prev_q     <= prev_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      fail_idx_q <= fail_idx_d;
      cycles_q   <= cycles_d;
      wdog_q     <= wdog_d;
    end
  end

  assign mem_rd_en = rd_en;
  assign mem_addr  = rd_en ? rd_addr : '0;
  assign busy      = scan_active;
  assign done      = verdict_st;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign fail_idx  = fail_idx_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_mem_order_checker.sv
// Self-checking bench for mem_order_checker: memory model, read-address
// scoreboard and per-scenario verdict/latency checks.
module tb_mem_order_checker;

  localparam int TOUT = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [7:0]  count = '0;
  logic [1:0]  mode = '0;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        busy, done, pass, timeout;
  logic [7:0]  fail_idx;
  logic [31:0] cycles;

  int n_asserts = 0;
  int n_fails = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_addr [$];

  mem_order_checker #(
    .DATA_W(32), .ADDR_W(32), .CNT_W(8), .WORD_BYTES(4),
    .HALT_PC(92), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .start(start),
    .base_addr(base_addr), .count(count), .mode(mode),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_idx(fail_idx), .cycles(cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    mem_rdata <= (mem_rd_en && mem.exists(mem_addr)) ? mem[mem_addr] : 32'd0;

  // Read-address scoreboard: every issued read must match the next expected address.
  always @(negedge clk) begin
    if (mem_rd_en) begin
      n_asserts++;
      if (exp_addr.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_read: got addr %h, none expected", mem_addr);
      end else begin
        logic [31:0] e;
        e = exp_addr.pop_front();
        if (mem_addr !== e) begin
          n_fails++;
          $display("FAIL read_addr: got %h want %h", mem_addr, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  function automatic bit ord_ok(logic [31:0] p, logic [31:0] c, logic [1:0] m);
    case (m)
      2'd0:    return c > p;
      2'd1:    return $signed(c) > $signed(p);
      2'd2:    return c >= p;
      default: return c < p;
    endcase
  endfunction

  function automatic int first_fail(logic [31:0] v [$], logic [1:0] m);
    for (int i = 1; i < v.size(); i++)
      if (!ord_ok(v[i-1], v[i], m)) return i;
    return 0;
  endfunction

  function automatic int exp_latency(int n, int k);
    if (n < 2) return 0;
    if (k != 0) return k + 3;
    return n + 2;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    pc = '0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    exp_addr.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Fill memory, drive config inputs and push the read addresses the scan must issue.
  task automatic load_scan(input logic [31:0] base, input logic [31:0] vals [$],
                           input logic [1:0] m, output int k);
    int n, nr;
    mem.delete();
    n = vals.size();
    for (int i = 0; i < n; i++) mem[base + 32'(i * 4)] = vals[i];
    k = first_fail(vals, m);
    nr = (n < 2) ? 0 : ((k != 0 && k + 2 < n) ? k + 2 : n);
    for (int i = 0; i < nr; i++) exp_addr.push_back(base + 32'(i * 4));
    base_addr = base;
    count = 8'(n);
    mode = m;
  endtask

  // Trigger on the next edge, then scramble the config inputs so latching is exercised.
  task automatic trigger_wait(input bit use_pc, output int lat);
    @(negedge clk);
    if (use_pc) pc = 32'd92;
    else start = 1'b1;
    @(posedge clk);
    #1;
    pc = '0;
    start = 1'b0;
    base_addr = $urandom();
    count = 8'($urandom());
    mode = 2'($urandom());
    lat = 0;
    while (!done && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_asserts++;
    if ({mem_rd_en, mem_addr, busy, done, pass, timeout, fail_idx, cycles} !== '0) begin
      n_fails++;
      $display("FAIL reset_outputs: rd_en=%b addr=%h busy=%b done=%b pass=%b tout=%b fidx=%0d cyc=%0d, want all 0",
               mem_rd_en, mem_addr, busy, done, pass, timeout, fail_idx, cycles);
    end
  endtask

  task automatic test_ascending();
    logic [31:0] v [$];
    int k, lat;
    do_reset();
    for (int i = 0; i < 12; i++) v.push_back(32'(i * 11));
    load_scan(32'd512, v, 2'd0, k);
    trigger_wait(1'b1, lat);
    n_asserts++;
    if (lat !== 14) begin n_fails++; $display("FAIL asc_latency: got %0d want 14", lat); end
    n_asserts++;
    if ({done, pass, timeout} !== 3'b110) begin
      n_fails++; $display("FAIL asc_verdict: done/pass/tout got %b want 110", {done, pass, timeout});
    end
    repeat (3) @(posedge clk);
    #1;
    n_asserts++;
    if (cycles !== 32'd16) begin n_fails++; $display("FAIL asc_cycles_frozen: got %0d want 16", cycles); end
    n_asserts++;
    if (exp_addr.size() != 0) begin n_fails++; $display("FAIL asc_reads_missing: %0d left want 0", exp_addr.size()); end
  endtask

  task automatic test_violation();
    logic [31:0] v [$];
    int k, lat;
    do_reset();
    v = '{32'd55, 32'd88, 32'd0, 32'd22, 32'd33, 32'd44, 32'd66, 32'd77};
    load_scan(32'd512, v, 2'd0, k);
    trigger_wait(1'b0, lat);
    n_asserts++;
    if (lat !== 5) begin n_fails++; $display("FAIL viol_latency: got %0d want 5", lat); end
    n_asserts++;
    if ({done, pass, fail_idx} !== {1'b1, 1'b0, 8'd2}) begin
      n_fails++; $display("FAIL viol_verdict: done=%b pass=%b fidx=%0d want 1 0 2", done, pass, fail_idx);
    end
    repeat (2) @(posedge clk);
    n_asserts++;
    if (exp_addr.size() != 0) begin n_fails++; $display("FAIL viol_reads_missing: %0d left want 0", exp_addr.size()); end
  endtask

  task automatic test_single();
    logic [31:0] v [$];
    int k, lat;
    for (int n = 0; n < 2; n++) begin
      do_reset();
      v.delete();
      for (int i = 0; i < n; i++) v.push_back(32'd7);
      load_scan(32'd512, v, 2'd3, k);
      trigger_wait(1'b0, lat);
      n_asserts++;
      if (lat !== 0) begin n_fails++; $display("FAIL single_latency n=%0d: got %0d want 0", n, lat); end
      n_asserts++;
      if ({done, pass, busy} !== 3'b110) begin
        n_fails++; $display("FAIL single_verdict n=%0d: done/pass/busy got %b want 110", n, {done, pass, busy});
      end
      repeat (3) @(posedge clk);
    end
  endtask

  // Table of scans across modes, signedness, equal neighbours and address wrap.
  task automatic test_modes();
    logic [31:0] tv [7][$];
    logic [31:0] tb_base [7];
    logic [1:0]  tm [7];
    int k, lat, el;
    tv[0] = '{32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd0, 32'd7}; tm[0] = 2'd1; tb_base[0] = 32'd512;
    tv[1] = '{32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd0, 32'd7}; tm[1] = 2'd0; tb_base[1] = 32'd512;
    tv[2] = '{32'd3, 32'd3, 32'd9, 32'd9, 32'd20};         tm[2] = 2'd2; tb_base[2] = 32'd64;
    tv[3] = '{32'd3, 32'd3, 32'd9, 32'd9, 32'd20};         tm[3] = 2'd0; tb_base[3] = 32'd64;
    tv[4] = '{32'd400, 32'd300, 32'd2, 32'd1};             tm[4] = 2'd3; tb_base[4] = 32'd1024;
    tv[5] = '{32'd90, 32'd50, 32'd50, 32'd10};             tm[5] = 2'd3; tb_base[5] = 32'd1024;
    tv[6] = '{32'd1, 32'd2, 32'd3, 32'd4};                 tm[6] = 2'd0; tb_base[6] = 32'hFFFF_FFF8;
    for (int t = 0; t < 7; t++) begin
      do_reset();
      load_scan(tb_base[t], tv[t], tm[t], k);
      el = exp_latency(tv[t].size(), k);
      trigger_wait(t[0], lat);
      n_asserts++;
      if (lat !== el) begin n_fails++; $display("FAIL modes_latency[%0d]: got %0d want %0d", t, lat, el); end
      n_asserts++;
      if ({done, pass, fail_idx} !== {1'b1, (k == 0), 8'(k)}) begin
        n_fails++;
        $display("FAIL modes_verdict[%0d]: done=%b pass=%b fidx=%0d want 1 %0b %0d", t, done, pass, fail_idx, k == 0, k);
      end
      repeat (2) @(posedge clk);
      n_asserts++;
      if (exp_addr.size() != 0) begin n_fails++; $display("FAIL modes_reads[%0d]: %0d left want 0", t, exp_addr.size()); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (TOUT - 1) @(posedge clk);
    #1;
    n_asserts++;
    if (done !== 1'b0) begin n_fails++; $display("FAIL tout_early: done=%b at cycle %0d want 0", done, TOUT - 1); end
    @(posedge clk);
    #1;
    n_asserts++;
    if ({done, timeout, pass, cycles} !== {3'b110, 32'(TOUT)}) begin
      n_fails++; $display("FAIL tout_verdict: done=%b tout=%b pass=%b cyc=%0d want 1 1 0 %0d", done, timeout, pass, cycles, TOUT);
    end
    count = 8'd4;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_asserts++;
    if ({done, timeout, pass, busy, cycles} !== {4'b1100, 32'(TOUT)}) begin
      n_fails++; $display("FAIL tout_sticky: done=%b tout=%b pass=%b busy=%b cyc=%0d want 1 1 0 0 %0d",
                          done, timeout, pass, busy, cycles, TOUT);
    end
  endtask

  task automatic test_expiry_tie();
    logic [31:0] v [$];
    int k;
    do_reset();
    v = '{32'd9};
    load_scan(32'd512, v, 2'd0, k);
    repeat (TOUT - 1) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_asserts++;
    if ({done, pass, timeout} !== 3'b110) begin
      n_fails++; $display("FAIL tie_trigger_wins: done/pass/tout got %b want 110", {done, pass, timeout});
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [31:0] v [$];
    int k, lat;
    do_reset();
    for (int i = 0; i < 12; i++) v.push_back(32'(100 + i));
    load_scan(32'd512, v, 2'd0, k);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_asserts++;
    if ({busy, mem_rd_en, mem_addr} !== {2'b11, 32'd532}) begin
      n_fails++; $display("FAIL mid_idx5: busy=%b rd_en=%b addr=%h want 1 1 214", busy, mem_rd_en, mem_addr);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_asserts++;
    if ({mem_rd_en, mem_addr, busy, done, pass, timeout, fail_idx, cycles} !== '0) begin
      n_fails++;
      $display("FAIL mid_reset_outputs: rd_en=%b addr=%h busy=%b done=%b pass=%b tout=%b fidx=%0d cyc=%0d, want all 0",
               mem_rd_en, mem_addr, busy, done, pass, timeout, fail_idx, cycles);
    end
    exp_addr.delete();
    @(negedge clk) rst = 1'b1;
    v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd6, 32'd9};
    load_scan(32'd256, v, 2'd0, k);
    trigger_wait(1'b0, lat);
    n_asserts++;
    if (lat !== exp_latency(9, k)) begin n_fails++; $display("FAIL mid_rescan_latency: got %0d want %0d", lat, exp_latency(9, k)); end
    n_asserts++;
    if ({done, pass, fail_idx} !== {1'b1, 1'b0, 8'(k)}) begin
      n_fails++; $display("FAIL mid_rescan_verdict: done=%b pass=%b fidx=%0d want 1 0 %0d", done, pass, fail_idx, k);
    end
    repeat (2) @(posedge clk);
    n_asserts++;
    if (exp_addr.size() != 0) begin n_fails++; $display("FAIL mid_rescan_reads: %0d left want 0", exp_addr.size()); end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_violation();
    test_single();
    test_modes();
    test_timeout();
    test_expiry_tie();
    test_reset_mid_scan();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
